// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the MIPS data memory: access-size encoding and
// byte-enable generation.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10,
    MEM_RSVD = 2'b11
  } mem_size_e;

  localparam int unsigned MAX_LANES = 16;

  // Enables are shifted by the lane offset, so a misaligned access shows up as
  // bits at or above `lanes`.
  function automatic logic [MAX_LANES-1:0] lane_mask(input mem_size_e   size,
                                                     input logic [3:0]  offset,
                                                     input int unsigned lanes);
    logic [MAX_LANES-1:0] base;
    base = '0;
    case (size)
      MEM_BYTE: base = MAX_LANES'(1);
      MEM_HALF: base = MAX_LANES'(3);
      MEM_WORD: base = MAX_LANES'((32'd1 << lanes) - 32'd1);
      default:  base = '0;
    endcase
    return base << offset;
  endfunction

endpackage

// File: rtl/data_memory_bytelane_if.sv
// MEM-stage request/response bus between the pipeline and the data memory.
interface data_memory_bytelane_if
  import mips_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8
) ();

  logic              MemoryRead;
  logic              MemoryWrite;
  mem_size_e         Size;
  logic              Unsigned;
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] WriteData;
  logic [DATA_W-1:0] ReadData;
  logic              ReadValid;
  logic              AccessError;

  modport master (
    output MemoryRead, MemoryWrite, Size, Unsigned, Address, WriteData,
    input  ReadData, ReadValid, AccessError
  );

  modport slave (
    input  MemoryRead, MemoryWrite, Size, Unsigned, Address, WriteData,
    output ReadData, ReadValid, AccessError
  );

endinterface

// File: rtl/dmem_load_align.sv
// Load alignment: moves the addressed byte/half/word down to bit 0 and
// sign- or zero-extends it to the full data width.
module dmem_load_align
  import mips_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OFF_W  = 2
) (
  input  logic [DATA_W-1:0] raw_word,
  input  mem_size_e         size,
  input  logic [OFF_W-1:0]  offset,
  input  logic              is_unsigned,
  output logic [DATA_W-1:0] result
);

  logic [DATA_W-1:0] shifted;
  logic              fill_b;
  logic              fill_h;

  always_comb begin
    shifted = raw_word >> {offset, 3'b000};
    fill_b  = !is_unsigned && shifted[7];
    fill_h  = !is_unsigned && shifted[15];
    result  = '0;
    case (size)
      MEM_BYTE: result = {{(DATA_W-8){fill_b}}, shifted[7:0]};
      MEM_HALF: result = {{(DATA_W-16){fill_h}}, shifted[15:0]};
      MEM_WORD: result = shifted;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/data_memory_bytelane.sv
// MIPS data memory with byte-lane stores, sub-word loads, a configurable read
// pipeline and alignment/range fault reporting.
module data_memory_bytelane
  import mips_mem_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned DEPTH        = 64,
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                   Clock,
  input  logic                   Reset_n,
  data_memory_bytelane_if.slave  bus
);

  localparam int unsigned LANES = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(LANES);
  localparam int unsigned IDX_W = ADDR_W - OFF_W;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic [DATA_W-1:0]    mem_q [DEPTH];

  logic [IDX_W-1:0]     idx;
  logic [OFF_W-1:0]     off;
  logic [AW-1:0]        word_addr;
  logic [MAX_LANES-1:0] mask;
  logic [LANES-1:0]     be;
  logic                 req;
  logic                 range_bad;
  logic                 size_bad;
  logic                 fault;
  logic                 wr_ok;
  logic                 rd_ok;
  logic [DATA_W-1:0]    wdata_lane;
  logic [DATA_W-1:0]    raw_word;
  logic [DATA_W-1:0]    aligned;

  logic [DATA_W-1:0]       data_q [READ_LATENCY];
  logic [DATA_W-1:0]       data_d [READ_LATENCY];
  logic [READ_LATENCY-1:0] valid_q;
  logic [READ_LATENCY-1:0] valid_d;
  logic                    err_q;
  logic                    err_d;

  always_comb begin
    idx        = bus.Address[ADDR_W-1:OFF_W];
    off        = bus.Address[OFF_W-1:0];
    word_addr  = idx[AW-1:0];
    mask       = lane_mask(bus.Size, 4'(off), LANES);
    be         = mask[LANES-1:0];
    req        = bus.MemoryRead || bus.MemoryWrite;
    range_bad  = {1'b0, idx} >= (IDX_W+1)'(DEPTH);
    size_bad   = 1'b0;
    case (bus.Size)
      MEM_HALF: size_bad = off[0];
      MEM_WORD: size_bad = (off != '0);
      MEM_RSVD: size_bad = 1'b1;
      default:  size_bad = 1'b0;
    endcase
    // Enables spilling past the top lane also mean a misaligned access.
    fault      = req && (size_bad || range_bad || (|(mask >> LANES)) ||
                         (bus.MemoryRead && bus.MemoryWrite));
    wr_ok      = bus.MemoryWrite && !fault;
    rd_ok      = bus.MemoryRead && !fault;
    wdata_lane = bus.WriteData << {off, 3'b000};
    raw_word   = mem_q[word_addr];
  end

  // The array itself is deliberately not reset.
  always_ff @(posedge Clock) begin
    if (wr_ok) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        if (be[l]) mem_q[word_addr][l*8 +: 8] <= wdata_lane[l*8 +: 8];
      end
    end
  end

  dmem_load_align #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_align (
    .raw_word    (raw_word),
    .size        (bus.Size),
    .offset      (off),
    .is_unsigned (bus.Unsigned),
    .result      (aligned)
  );

  // Data stages only load on a valid beat so ReadData holds between loads.
  always_comb begin
    data_d     = data_q;
    valid_d    = '0;
    valid_d[0] = rd_ok;
    data_d[0]  = rd_ok ? aligned : data_q[0];
    for (int unsigned s = 1; s < READ_LATENCY; s++) begin
      valid_d[s] = valid_q[s-1];
      data_d[s]  = valid_q[s-1] ? data_q[s-1] : data_q[s];
    end
    err_d = fault;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned s = 0; s < READ_LATENCY; s++) data_q[s] <= '0;
      valid_q <= '0;
      err_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign bus.ReadData    = data_q[READ_LATENCY-1];
  assign bus.ReadValid   = valid_q[READ_LATENCY-1];
  assign bus.AccessError = err_q;

endmodule

// File: tb/tb_data_memory_bytelane.sv
// Directed bench: three copies of the memory (read latency 1, 2, 3) driven with
// identical requests, each checked against hand-computed results.
module tb_data_memory_bytelane;
  import mips_mem_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic [31:0] vals [8];

  data_memory_bytelane_if #(.DATA_W(32), .ADDR_W(9)) bus1 ();
  data_memory_bytelane_if #(.DATA_W(32), .ADDR_W(9)) bus2 ();
  data_memory_bytelane_if #(.DATA_W(32), .ADDR_W(9)) bus3 ();

  data_memory_bytelane #(.DATA_W(32), .DEPTH(64), .ADDR_W(9), .READ_LATENCY(1)) dut1 (
    .Clock(clk), .Reset_n(rst_n), .bus(bus1.slave));
  data_memory_bytelane #(.DATA_W(32), .DEPTH(64), .ADDR_W(9), .READ_LATENCY(2)) dut2 (
    .Clock(clk), .Reset_n(rst_n), .bus(bus2.slave));
  data_memory_bytelane #(.DATA_W(32), .DEPTH(64), .ADDR_W(9), .READ_LATENCY(3)) dut3 (
    .Clock(clk), .Reset_n(rst_n), .bus(bus3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input mem_size_e sz, input logic uns,
                       input logic [8:0] addr, input logic [31:0] wd);
    bus1.MemoryRead = rd;  bus2.MemoryRead = rd;  bus3.MemoryRead = rd;
    bus1.MemoryWrite = wr; bus2.MemoryWrite = wr; bus3.MemoryWrite = wr;
    bus1.Size = sz;        bus2.Size = sz;        bus3.Size = sz;
    bus1.Unsigned = uns;   bus2.Unsigned = uns;   bus3.Unsigned = uns;
    bus1.Address = addr;   bus2.Address = addr;   bus3.Address = addr;
    bus1.WriteData = wd;   bus2.WriteData = wd;   bus3.WriteData = wd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, MEM_WORD, 1'b0, 9'h000, 32'h0);
  endtask

  function automatic logic [31:0] valids();
    return 32'({bus1.ReadValid, bus2.ReadValid, bus3.ReadValid});
  endfunction

  function automatic logic [31:0] errs();
    return 32'({bus1.AccessError, bus2.AccessError, bus3.AccessError});
  endfunction

  function automatic logic [31:0] rdata(input int lat);
    case (lat)
      1:       return bus1.ReadData;
      2:       return bus2.ReadData;
      default: return bus3.ReadData;
    endcase
  endfunction

  function automatic logic rvalid(input int lat);
    case (lat)
      1:       return bus1.ReadValid;
      2:       return bus2.ReadValid;
      default: return bus3.ReadValid;
    endcase
  endfunction

  task automatic do_store(input mem_size_e sz, input logic [8:0] addr, input logic [31:0] wd,
                          input string tag);
    drive(1'b0, 1'b1, sz, 1'b0, addr, wd);
    step();
    idle();
    check({tag, "_err"}, errs(), 32'h0);
  endtask

  task automatic do_load(input mem_size_e sz, input logic uns, input logic [8:0] addr,
                         input logic [31:0] exp, input string tag);
    drive(1'b1, 1'b0, sz, uns, addr, 32'h0);
    step();
    idle();
    check({tag, "_v1"}, valids(), 32'b100);
    check({tag, "_d1"}, bus1.ReadData, exp);
    step();
    check({tag, "_v2"}, valids(), 32'b010);
    check({tag, "_d2"}, bus2.ReadData, exp);
    step();
    check({tag, "_v3"}, valids(), 32'b001);
    check({tag, "_d3"}, bus3.ReadData, exp);
  endtask

  task automatic fault_req(input logic rd, input logic wr, input mem_size_e sz,
                           input logic [8:0] addr, input logic [31:0] wd, input string tag);
    drive(rd, wr, sz, 1'b0, addr, wd);
    step();
    idle();
    check({tag, "_err"}, errs(), 32'b111);
    check({tag, "_nv0"}, valids(), 32'b000);
    step();
    check({tag, "_err_clr"}, errs(), 32'b000);
    check({tag, "_nv1"}, valids(), 32'b000);
    step();
    check({tag, "_nv2"}, valids(), 32'b000);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    idle();

    // Reset state
    step();
    step();
    check("rst_valid", valids(), 32'b000);
    check("rst_err", errs(), 32'b000);
    check("rst_d1", bus1.ReadData, 32'h0);
    check("rst_d2", bus2.ReadData, 32'h0);
    check("rst_d3", bus3.ReadData, 32'h0);

    // Reset in the middle of a load
    rst_n = 1'b1;
    step();
    drive(1'b1, 1'b0, MEM_WORD, 1'b0, 9'h000, 32'h0);
    step();
    idle();
    rst_n = 1'b0;
    #1;
    check("midrst_valid_a", valids(), 32'b000);
    check("midrst_d2", bus2.ReadData, 32'h0);
    step();
    check("midrst_valid_b", valids(), 32'b000);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("midrst_after", valids(), 32'b000);
      check("midrst_after_err", errs(), 32'b000);
    end

    // Word store / load
    do_store(MEM_WORD, 9'h010, 32'hDEADBEEF, "sw10");
    do_load(MEM_WORD, 1'b0, 9'h010, 32'hDEADBEEF, "lw10");

    // Byte store into lane 1, byte loads
    do_store(MEM_BYTE, 9'h011, 32'hAAAAAA7F, "sb11");
    do_load(MEM_WORD, 1'b0, 9'h010, 32'hDEAD7FEF, "lw10b");
    do_load(MEM_BYTE, 1'b0, 9'h013, 32'hFFFFFFDE, "lb13");
    do_load(MEM_BYTE, 1'b1, 9'h013, 32'h000000DE, "lbu13");

    // Half store into upper half, half loads
    do_store(MEM_WORD, 9'h020, 32'h12345678, "sw20");
    do_store(MEM_HALF, 9'h022, 32'h55558001, "sh22");
    do_load(MEM_HALF, 1'b0, 9'h022, 32'hFFFF8001, "lh22");
    do_load(MEM_HALF, 1'b1, 9'h022, 32'h00008001, "lhu22");
    do_load(MEM_WORD, 1'b0, 9'h020, 32'h80015678, "lw20");
    do_load(MEM_HALF, 1'b0, 9'h020, 32'h00005678, "lh20");
    do_load(MEM_BYTE, 1'b0, 9'h020, 32'h00000078, "lb20");

    // Faults
    fault_req(1'b1, 1'b0, MEM_HALF, 9'h021, 32'h0, "f_lh21");
    fault_req(1'b1, 1'b0, MEM_WORD, 9'h022, 32'h0, "f_lw22");
    fault_req(1'b1, 1'b0, MEM_RSVD, 9'h020, 32'h0, "f_rsvd");
    fault_req(1'b1, 1'b0, MEM_WORD, 9'h100, 32'h0, "f_range");
    fault_req(1'b1, 1'b1, MEM_WORD, 9'h020, 32'hFFFFFFFF, "f_rdwr");
    fault_req(1'b0, 1'b1, MEM_HALF, 9'h021, 32'hFFFFFFFF, "f_sh21");
    fault_req(1'b0, 1'b1, MEM_WORD, 9'h120, 32'hFFFFFFFF, "f_sw_range");
    fault_req(1'b0, 1'b1, MEM_RSVD, 9'h020, 32'hFFFFFFFF, "f_sw_rsvd");
    do_load(MEM_WORD, 1'b0, 9'h020, 32'h80015678, "lw20_kept");

    // Streaming loads
    for (int i = 0; i < 8; i++) begin
      vals[i] = {8'(i), 8'hA5, 8'(i * 3), 8'h5A};
      do_store(MEM_WORD, 9'(i * 4), vals[i], "sw_stream");
    end
    for (int c = 0; c < 10; c++) begin
      if (c < 8) drive(1'b1, 1'b0, MEM_WORD, 1'b0, 9'(c * 4), 32'h0);
      else idle();
      step();
      for (int lat = 1; lat <= 3; lat++) begin
        int k;
        k = c - (lat - 1);
        check("stream_valid", 32'(rvalid(lat)), 32'((k >= 0) && (k < 8)));
        if (k >= 0) check("stream_data", rdata(lat), vals[(k > 7) ? 7 : k]);
      end
    end
    idle();

    // Reserved-size request right behind a good load
    drive(1'b1, 1'b0, MEM_WORD, 1'b0, 9'h00C, 32'h0);
    step();
    drive(1'b1, 1'b0, MEM_RSVD, 1'b0, 9'h010, 32'h0);
    check("mix_v1", valids(), 32'b100);
    check("mix_d1", bus1.ReadData, vals[3]);
    step();
    idle();
    check("mix_v2", valids(), 32'b010);
    check("mix_d2", bus2.ReadData, vals[3]);
    check("mix_err", errs(), 32'b111);
    step();
    check("mix_v3", valids(), 32'b001);
    check("mix_d3", bus3.ReadData, vals[3]);
    check("mix_err_clr", errs(), 32'b000);
    step();
    check("mix_v4", valids(), 32'b000);
    check("mix_hold3", bus3.ReadData, vals[3]);

    // Read-after-write on consecutive cycles
    do_store(MEM_WORD, 9'h018, 32'hCAFEF00D, "sw18");
    do_load(MEM_WORD, 1'b0, 9'h018, 32'hCAFEF00D, "raw18");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
